// File: rtl/mc_ctrl_if.sv
// Memory handshake bundle between the multicycle controller and its instruction/data memories.
// The controller (master) raises the requests; the memories (slave) return the acknowledges.
interface mc_ctrl_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        output imem_ack,
        output dmem_ack
    );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle RISC-V control FSM (FETCH, DECODE, EXEC, MEM, WB, TRAP).
// Decoded fields are latched in DECODE and drive the datapath outputs until the next DECODE.
// Memory waits are bounded by MEM_TIMEOUT request cycles (0 = unbounded); expiry traps.
// Optional feature: define MC_CTRL_ILLEGAL_EN to trap on undecoded instructions instead of
// executing them as a nop.
module mc_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic [6:0] Funct7,
    input  logic [2:0] Funct3,
    input  logic       Zero,
    mc_ctrl_if.master  mem,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [5:0] EXTOp,
    output logic [4:0] ALUOp,
    output logic [2:0] NPCOp,
    output logic       ALUSrc,
    output logic [1:0] WDSel,
    output logic [2:0] DMType,
    output logic [2:0] state,
    output logic       bus_err,
    output logic       illegal
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ClsNone, ClsAlu, ClsLoad, ClsStore, ClsBranch, ClsLui, ClsAuipc, ClsJal, ClsJalr
    } cls_e;

    // Immediate-extender select
    localparam logic [5:0] ExtNone  = 6'b000000;
    localparam logic [5:0] ExtShamt = 6'b100000;
    localparam logic [5:0] ExtI     = 6'b010000;
    localparam logic [5:0] ExtS     = 6'b001000;
    localparam logic [5:0] ExtB     = 6'b000100;
    localparam logic [5:0] ExtU     = 6'b000010;
    localparam logic [5:0] ExtJ     = 6'b000001;
    // Next-PC select
    localparam logic [2:0] NpcPlus4  = 3'b000;
    localparam logic [2:0] NpcBranch = 3'b001;
    localparam logic [2:0] NpcJump   = 3'b010;
    localparam logic [2:0] NpcJalr   = 3'b100;
    // ALU operation
    localparam logic [4:0] AluNop   = 5'b00000;
    localparam logic [4:0] AluLui   = 5'b00001;
    localparam logic [4:0] AluAuipc = 5'b00010;
    localparam logic [4:0] AluAdd   = 5'b00011;
    localparam logic [4:0] AluSub   = 5'b00100;
    localparam logic [4:0] AluBne   = 5'b00101;
    localparam logic [4:0] AluBlt   = 5'b00110;
    localparam logic [4:0] AluBge   = 5'b00111;
    localparam logic [4:0] AluBltu  = 5'b01000;
    localparam logic [4:0] AluBgeu  = 5'b01001;
    localparam logic [4:0] AluSlt   = 5'b01010;
    localparam logic [4:0] AluSltu  = 5'b01011;
    localparam logic [4:0] AluXor   = 5'b01100;
    localparam logic [4:0] AluOr    = 5'b01101;
    localparam logic [4:0] AluAnd   = 5'b01110;
    localparam logic [4:0] AluSll   = 5'b01111;
    localparam logic [4:0] AluSrl   = 5'b10000;
    localparam logic [4:0] AluSra   = 5'b10001;
    // Register write-back source
    localparam logic [1:0] WdAlu = 2'b00;
    localparam logic [1:0] WdMem = 2'b01;
    localparam logic [1:0] WdPc  = 2'b10;
    // Data memory access type
    localparam logic [2:0] DmWord  = 3'b000;
    localparam logic [2:0] DmHalf  = 3'b001;
    localparam logic [2:0] DmHalfU = 3'b010;
    localparam logic [2:0] DmByte  = 3'b011;
    localparam logic [2:0] DmByteU = 3'b100;

    localparam bit             TimeoutEn   = (MEM_TIMEOUT != 0);
    // Counter value in the last allowed un-acknowledged request cycle
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       ext_q, ext_d;
    logic [4:0]       alu_q, alu_d;
    logic             src_q, src_d;
    logic [1:0]       wd_q, wd_d;
    logic [2:0]       dm_q, dm_d;
    logic             bus_err_q, bus_err_d;
`ifdef MC_CTRL_ILLEGAL_EN
    logic             illegal_q, illegal_d;
`endif

    cls_e       dec_cls;
    logic [5:0] dec_ext;
    logic [4:0] dec_alu;
    logic       dec_src;
    logic [1:0] dec_wd;
    logic [2:0] dec_dm;
    logic       timeout_hit;

    assign timeout_hit = TimeoutEn && (cnt_q == TimeoutLast);

    // Instruction decode of the external IR fields; undecoded combinations collapse to nop
    always_comb begin
        dec_cls = ClsNone;
        dec_ext = ExtNone;
        dec_alu = AluNop;
        dec_src = 1'b0;
        dec_wd  = WdAlu;
        dec_dm  = DmWord;
        case (Op)
            7'b0110011: begin
                dec_cls = ClsAlu;
                case ({Funct7, Funct3})
                    10'b0000000_000: dec_alu = AluAdd;
                    10'b0100000_000: dec_alu = AluSub;
                    10'b0000000_001: dec_alu = AluSll;
                    10'b0000000_010: dec_alu = AluSlt;
                    10'b0000000_011: dec_alu = AluSltu;
                    10'b0000000_100: dec_alu = AluXor;
                    10'b0000000_101: dec_alu = AluSrl;
                    10'b0100000_101: dec_alu = AluSra;
                    10'b0000000_110: dec_alu = AluOr;
                    10'b0000000_111: dec_alu = AluAnd;
                    default:         dec_cls = ClsNone;
                endcase
            end
            7'b0010011: begin
                dec_cls = ClsAlu;
                dec_src = 1'b1;
                dec_ext = ExtI;
                case (Funct3)
                    3'b000: dec_alu = AluAdd;
                    3'b010: dec_alu = AluSlt;
                    3'b011: dec_alu = AluSltu;
                    3'b100: dec_alu = AluXor;
                    3'b110: dec_alu = AluOr;
                    3'b111: dec_alu = AluAnd;
                    3'b001: begin
                        dec_ext = ExtShamt;
                        dec_alu = AluSll;
                        if (Funct7 != 7'b0000000) dec_cls = ClsNone;
                    end
                    default: begin
                        dec_ext = ExtShamt;
                        if (Funct7 == 7'b0000000)      dec_alu = AluSrl;
                        else if (Funct7 == 7'b0100000) dec_alu = AluSra;
                        else                           dec_cls = ClsNone;
                    end
                endcase
            end
            7'b0000011: begin
                dec_cls = ClsLoad;
                dec_src = 1'b1;
                dec_ext = ExtI;
                dec_alu = AluAdd;
                dec_wd  = WdMem;
                case (Funct3)
                    3'b000:  dec_dm = DmByte;
                    3'b001:  dec_dm = DmHalf;
                    3'b010:  dec_dm = DmWord;
                    3'b100:  dec_dm = DmByteU;
                    3'b101:  dec_dm = DmHalfU;
                    default: dec_cls = ClsNone;
                endcase
            end
            7'b0100011: begin
                dec_cls = ClsStore;
                dec_src = 1'b1;
                dec_ext = ExtS;
                dec_alu = AluAdd;
                case (Funct3)
                    3'b000:  dec_dm = DmByte;
                    3'b001:  dec_dm = DmHalf;
                    3'b010:  dec_dm = DmWord;
                    default: dec_cls = ClsNone;
                endcase
            end
            7'b1100011: begin
                dec_cls = ClsBranch;
                dec_ext = ExtB;
                case (Funct3)
                    3'b000:  dec_alu = AluSub;
                    3'b001:  dec_alu = AluBne;
                    3'b100:  dec_alu = AluBlt;
                    3'b101:  dec_alu = AluBge;
                    3'b110:  dec_alu = AluBltu;
                    3'b111:  dec_alu = AluBgeu;
                    default: dec_cls = ClsNone;
                endcase
            end
            7'b0110111: begin
                dec_cls = ClsLui;
                dec_src = 1'b1;
                dec_ext = ExtU;
                dec_alu = AluLui;
            end
            7'b0010111: begin
                dec_cls = ClsAuipc;
                dec_src = 1'b1;
                dec_ext = ExtU;
                dec_alu = AluAuipc;
            end
            7'b1101111: begin
                dec_cls = ClsJal;
                dec_ext = ExtJ;
                dec_wd  = WdPc;
            end
            7'b1100111: begin
                dec_cls = ClsJalr;
                dec_src = 1'b1;
                dec_ext = ExtI;
                dec_alu = AluAdd;
                dec_wd  = WdPc;
                if (Funct3 != 3'b000) dec_cls = ClsNone;
            end
            default: dec_cls = ClsNone;
        endcase
        // An undecoded instruction latches as a clean nop
        if (dec_cls == ClsNone) begin
            dec_ext = ExtNone;
            dec_alu = AluNop;
            dec_src = 1'b0;
            dec_wd  = WdAlu;
            dec_dm  = DmWord;
        end
    end

    // Next-state, timeout counter and strobe generation
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        cnt_d     = '0;
        ext_d     = ext_q;
        alu_d     = alu_q;
        src_d     = src_q;
        wd_d      = wd_q;
        dm_d      = dm_q;
        bus_err_d = bus_err_q;
`ifdef MC_CTRL_ILLEGAL_EN
        illegal_d = illegal_q;
`endif
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        NPCOp     = NpcPlus4;
        case (state_q)
            StFetch: begin
                if (mem.imem_ack) begin
                    IRWrite = 1'b1;
                    state_d = StDecode;
                end else if (timeout_hit) begin
                    state_d   = StTrap;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDecode: begin
                cls_d = dec_cls;
                ext_d = dec_ext;
                alu_d = dec_alu;
                src_d = dec_src;
                wd_d  = dec_wd;
                dm_d  = dec_dm;
`ifdef MC_CTRL_ILLEGAL_EN
                if (dec_cls == ClsNone) begin
                    state_d   = StTrap;
                    illegal_d = 1'b1;
                end else begin
                    state_d = StExec;
                end
`else
                state_d = StExec;
`endif
            end
            StExec: begin
                case (cls_q)
                    ClsLoad, ClsStore: state_d = StMem;
                    ClsBranch: begin
                        PCWrite = 1'b1;
                        NPCOp   = Zero ? NpcBranch : NpcPlus4;
                        state_d = StFetch;
                    end
                    ClsNone: begin
                        PCWrite = 1'b1;
                        state_d = StFetch;
                    end
                    default: state_d = StWb;
                endcase
            end
            StMem: begin
                MemWrite = (cls_q == ClsStore);
                if (mem.dmem_ack) begin
                    if (cls_q == ClsStore) begin
                        PCWrite = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (timeout_hit) begin
                    state_d   = StTrap;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWb: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                if (cls_q == ClsJal)       NPCOp = NpcJump;
                else if (cls_q == ClsJalr) NPCOp = NpcJalr;
                state_d = StFetch;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
        // Reset kills every strobe immediately, even mid-instruction
        if (rst) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            NPCOp    = NpcPlus4;
        end
    end

    // State, counter and latched decode registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            cls_q     <= ClsNone;
            cnt_q     <= '0;
            ext_q     <= ExtNone;
            alu_q     <= AluNop;
            src_q     <= 1'b0;
            wd_q      <= WdAlu;
            dm_q      <= DmWord;
            bus_err_q <= 1'b0;
`ifdef MC_CTRL_ILLEGAL_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            cnt_q     <= cnt_d;
            ext_q     <= ext_d;
            alu_q     <= alu_d;
            src_q     <= src_d;
            wd_q      <= wd_d;
            dm_q      <= dm_d;
            bus_err_q <= bus_err_d;
`ifdef MC_CTRL_ILLEGAL_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Requests are Moore outputs, forced low while reset is held
    assign mem.imem_req = (state_q == StFetch) && !rst;
    assign mem.dmem_req = (state_q == StMem) && !rst;

    assign EXTOp   = ext_q;
    assign ALUOp   = alu_q;
    assign ALUSrc  = src_q;
    assign WDSel   = wd_q;
    assign DMType  = dm_q;
    assign state   = state_q;
    assign bus_err = bus_err_q;
`ifdef MC_CTRL_ILLEGAL_EN
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl with MEM_TIMEOUT=4.
module tb_mc_ctrl;
    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       zero;
    logic       IRWrite, PCWrite, RegWrite, MemWrite, ALUSrc, bus_err, illegal;
    logic [5:0] EXTOp;
    logic [4:0] ALUOp;
    logic [2:0] NPCOp, DMType, state;
    logic [1:0] WDSel;

    int checks   = 0;
    int failures = 0;
    int pcw_cnt  = 0;
    int rw_cnt   = 0;

    mc_ctrl_if mem_bus ();

    mc_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Op       (op),
        .Funct7   (f7),
        .Funct3   (f3),
        .Zero     (zero),
        .mem      (mem_bus),
        .IRWrite  (IRWrite),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .EXTOp    (EXTOp),
        .ALUOp    (ALUOp),
        .NPCOp    (NPCOp),
        .ALUSrc   (ALUSrc),
        .WDSel    (WDSel),
        .DMType   (DMType),
        .state    (state),
        .bus_err  (bus_err),
        .illegal  (illegal)
    );

    // {imem_req, dmem_req, IRWrite, PCWrite, RegWrite, MemWrite, NPCOp, state}
    logic [11:0] obs_v;
    // {EXTOp, ALUOp, ALUSrc, WDSel, DMType}
    logic [16:0] dec_v;
    logic [30:0] obs_all;
    assign obs_v   = {mem_bus.imem_req, mem_bus.dmem_req, IRWrite, PCWrite, RegWrite, MemWrite,
                      NPCOp, state};
    assign dec_v   = {EXTOp, ALUOp, ALUSrc, WDSel, DMType};
    assign obs_all = {obs_v[11:6], EXTOp, ALUOp, NPCOp, ALUSrc, WDSel, DMType, state, bus_err,
                      illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (PCWrite)  pcw_cnt <= pcw_cnt + 1;
        if (RegWrite) rw_cnt  <= rw_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic set_instr(input logic [31:0] instr);
        op = instr[6:0];
        f3 = instr[14:12];
        f7 = instr[31:25];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_bus.imem_ack = 1'b0;
        mem_bus.dmem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (obs_all !== 31'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", obs_all);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (mem_bus.imem_req !== 1'b1 || state !== 3'd0) begin
            failures++;
            $display("FAIL reset_release imem_req=%b state=%0d exp 1/0", mem_bus.imem_req, state);
        end
        checks++;
        if ({bus_err, illegal, dec_v} !== 19'd0) begin
            failures++;
            $display("FAIL reset_regs got=%b exp=0", {bus_err, illegal, dec_v});
        end
        @(negedge clk);
    endtask

    task automatic test_addi();
        logic [11:0] ev [5];
        logic        ia [5];
        int          pc0, rw0;
        ev = '{{6'b101000, 3'b000, 3'd0}, {6'b000000, 3'b000, 3'd1}, {6'b000000, 3'b000, 3'd2},
               {6'b000110, 3'b000, 3'd4}, {6'b100000, 3'b000, 3'd0}};
        ia = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        set_instr(32'h00500093);
        pc0 = pcw_cnt;
        rw0 = rw_cnt;
        for (int i = 0; i < 5; i++) begin
            mem_bus.imem_ack = ia[i];
            mem_bus.dmem_ack = 1'b0;
            #1;
            checks++;
            if (obs_v !== ev[i]) begin
                failures++;
                $display("FAIL addi_cyc%0d got=%b exp=%b", i, obs_v, ev[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (dec_v !== {6'b010000, 5'b00011, 1'b1, 2'b00, 3'b000}) begin
            failures++;
            $display("FAIL addi_fields got=%b exp=%b", dec_v,
                     {6'b010000, 5'b00011, 1'b1, 2'b00, 3'b000});
        end
        checks++;
        if (pcw_cnt - pc0 != 1 || rw_cnt - rw0 != 1) begin
            failures++;
            $display("FAIL addi_counts pcw=%0d rw=%0d exp 1/1", pcw_cnt - pc0, rw_cnt - rw0);
        end
    endtask

    task automatic test_load();
        logic [11:0] ev [8];
        logic        ia [8];
        logic        da [8];
        int          pc0, rw0;
        ev = '{{6'b101000, 3'b000, 3'd0}, {6'b000000, 3'b000, 3'd1}, {6'b000000, 3'b000, 3'd2},
               {6'b010000, 3'b000, 3'd3}, {6'b010000, 3'b000, 3'd3}, {6'b010000, 3'b000, 3'd3},
               {6'b000110, 3'b000, 3'd4}, {6'b100000, 3'b000, 3'd0}};
        ia = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        da = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        set_instr(32'h0000A103);
        pc0 = pcw_cnt;
        rw0 = rw_cnt;
        for (int i = 0; i < 8; i++) begin
            mem_bus.imem_ack = ia[i];
            mem_bus.dmem_ack = da[i];
            #1;
            checks++;
            if (obs_v !== ev[i]) begin
                failures++;
                $display("FAIL lw_cyc%0d got=%b exp=%b", i, obs_v, ev[i]);
            end
            @(negedge clk);
        end
        mem_bus.dmem_ack = 1'b0;
        checks++;
        if (dec_v !== {6'b010000, 5'b00011, 1'b1, 2'b01, 3'b000}) begin
            failures++;
            $display("FAIL lw_fields got=%b exp=%b", dec_v,
                     {6'b010000, 5'b00011, 1'b1, 2'b01, 3'b000});
        end
        checks++;
        if (pcw_cnt - pc0 != 1 || rw_cnt - rw0 != 1 || bus_err !== 1'b0) begin
            failures++;
            $display("FAIL lw_counts pcw=%0d rw=%0d bus_err=%b exp 1/1/0", pcw_cnt - pc0,
                     rw_cnt - rw0, bus_err);
        end
    endtask

    task automatic test_branch();
        logic [11:0] ev [8];
        logic        ia [8];
        logic        da [8];
        logic        zv [8];
        int          rw0;
        // Acks raised while the matching request is low must have no effect
        ev = '{{6'b101000, 3'b000, 3'd0}, {6'b000000, 3'b000, 3'd1}, {6'b000100, 3'b001, 3'd2},
               {6'b101000, 3'b000, 3'd0}, {6'b000000, 3'b000, 3'd1}, {6'b000100, 3'b000, 3'd2},
               {6'b100000, 3'b000, 3'd0}, {6'b100000, 3'b000, 3'd0}};
        ia = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        da = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        zv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        set_instr(32'h00000463);
        rw0 = rw_cnt;
        for (int i = 0; i < 8; i++) begin
            mem_bus.imem_ack = ia[i];
            mem_bus.dmem_ack = da[i];
            zero = zv[i];
            #1;
            checks++;
            if (obs_v !== ev[i]) begin
                failures++;
                $display("FAIL beq_cyc%0d got=%b exp=%b", i, obs_v, ev[i]);
            end
            @(negedge clk);
        end
        mem_bus.dmem_ack = 1'b0;
        checks++;
        if (dec_v !== {6'b000100, 5'b00100, 1'b0, 2'b00, 3'b000} || rw_cnt != rw0) begin
            failures++;
            $display("FAIL beq_fields got=%b rw=%0d exp=%b rw=0", dec_v, rw_cnt - rw0,
                     {6'b000100, 5'b00100, 1'b0, 2'b00, 3'b000});
        end
    endtask

    task automatic test_jal();
        logic [11:0] ev [5];
        logic        ia [5];
        ev = '{{6'b101000, 3'b000, 3'd0}, {6'b000000, 3'b000, 3'd1}, {6'b000000, 3'b000, 3'd2},
               {6'b000110, 3'b010, 3'd4}, {6'b100000, 3'b000, 3'd0}};
        ia = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        set_instr(32'h0080006F);
        for (int i = 0; i < 5; i++) begin
            mem_bus.imem_ack = ia[i];
            #1;
            checks++;
            if (obs_v !== ev[i]) begin
                failures++;
                $display("FAIL jal_cyc%0d got=%b exp=%b", i, obs_v, ev[i]);
            end
            @(negedge clk);
        end
        checks++;
        if ({EXTOp, WDSel} !== {6'b000001, 2'b10}) begin
            failures++;
            $display("FAIL jal_fields got=%b exp=%b", {EXTOp, WDSel}, {6'b000001, 2'b10});
        end
    endtask

    task automatic test_timeout();
        logic [11:0] ev [6];
        logic        ia [6];
        ev = '{{6'b100000, 3'b000, 3'd0}, {6'b100000, 3'b000, 3'd0}, {6'b100000, 3'b000, 3'd0},
               {6'b100000, 3'b000, 3'd0}, {6'b000000, 3'b000, 3'd5}, {6'b000000, 3'b000, 3'd5}};
        ia = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            mem_bus.imem_ack = ia[i];
            mem_bus.dmem_ack = ia[i];
            #1;
            checks++;
            if (obs_v !== ev[i]) begin
                failures++;
                $display("FAIL timeout_cyc%0d got=%b exp=%b", i, obs_v, ev[i]);
            end
            @(negedge clk);
        end
        mem_bus.imem_ack = 1'b0;
        mem_bus.dmem_ack = 1'b0;
        checks++;
        if (bus_err !== 1'b1 || illegal !== 1'b0 || state !== 3'd5) begin
            failures++;
            $display("FAIL timeout_trap bus_err=%b illegal=%b state=%0d exp 1/0/5", bus_err,
                     illegal, state);
        end
    endtask

    task automatic test_ack_at_limit();
        logic [11:0] ev [5];
        logic        ia [5];
        ev = '{{6'b100000, 3'b000, 3'd0}, {6'b100000, 3'b000, 3'd0}, {6'b100000, 3'b000, 3'd0},
               {6'b101000, 3'b000, 3'd0}, {6'b000000, 3'b000, 3'd1}};
        ia = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        set_instr(32'h00500093);
        for (int i = 0; i < 5; i++) begin
            mem_bus.imem_ack = ia[i];
            #1;
            checks++;
            if (obs_v !== ev[i]) begin
                failures++;
                $display("FAIL acklimit_cyc%0d got=%b exp=%b", i, obs_v, ev[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (bus_err !== 1'b0) begin
            failures++;
            $display("FAIL acklimit_bus_err got=%b exp=0", bus_err);
        end
    endtask

    task automatic test_illegal();
        logic [11:0] ev [4];
        logic        ia [4];
        int          rw0;
`ifdef MC_CTRL_ILLEGAL_EN
        ev = '{{6'b101000, 3'b000, 3'd0}, {6'b000000, 3'b000, 3'd1}, {6'b000000, 3'b000, 3'd5},
               {6'b000000, 3'b000, 3'd5}};
`else
        ev = '{{6'b101000, 3'b000, 3'd0}, {6'b000000, 3'b000, 3'd1}, {6'b000100, 3'b000, 3'd2},
               {6'b100000, 3'b000, 3'd0}};
`endif
        ia = '{1'b1, 1'b0, 1'b0, 1'b0};
        set_instr(32'h0000007F);
        rw0 = rw_cnt;
        for (int i = 0; i < 4; i++) begin
            mem_bus.imem_ack = ia[i];
            #1;
            checks++;
            if (obs_v !== ev[i]) begin
                failures++;
                $display("FAIL illegal_cyc%0d got=%b exp=%b", i, obs_v, ev[i]);
            end
            @(negedge clk);
        end
        checks++;
`ifdef MC_CTRL_ILLEGAL_EN
        if (illegal !== 1'b1 || bus_err !== 1'b0 || rw_cnt != rw0) begin
            failures++;
            $display("FAIL illegal_flag illegal=%b bus_err=%b exp 1/0", illegal, bus_err);
        end
`else
        if (illegal !== 1'b0 || dec_v !== 17'd0 || rw_cnt != rw0) begin
            failures++;
            $display("FAIL illegal_nop illegal=%b fields=%b rw=%0d exp 0/0/0", illegal, dec_v,
                     rw_cnt - rw0);
        end
`endif
    endtask

    task automatic test_store_reset();
        logic [11:0] ev [4];
        logic        ia [4];
        int          pc0;
        ev = '{{6'b101000, 3'b000, 3'd0}, {6'b000000, 3'b000, 3'd1}, {6'b000000, 3'b000, 3'd2},
               {6'b010001, 3'b000, 3'd3}};
        ia = '{1'b1, 1'b0, 1'b0, 1'b0};
        set_instr(32'h0020A023);
        pc0 = pcw_cnt;
        for (int i = 0; i < 4; i++) begin
            mem_bus.imem_ack = ia[i];
            mem_bus.dmem_ack = 1'b0;
            #1;
            checks++;
            if (obs_v !== ev[i]) begin
                failures++;
                $display("FAIL sw_cyc%0d got=%b exp=%b", i, obs_v, ev[i]);
            end
            @(negedge clk);
        end
        // Still in MEM; pulse reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs_all !== 31'd0) begin
            failures++;
            $display("FAIL sw_reset_outputs got=%b exp=0", obs_all);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (mem_bus.imem_req !== 1'b1 || state !== 3'd0 || pcw_cnt != pc0) begin
            failures++;
            $display("FAIL sw_reset_release imem_req=%b state=%0d pcw=%0d exp 1/0/0",
                     mem_bus.imem_req, state, pcw_cnt - pc0);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        zero = 1'b0;
        mem_bus.imem_ack = 1'b0;
        mem_bus.dmem_ack = 1'b0;
        set_instr(32'h00000013);
        test_reset();
        do_reset();
        test_addi();
        do_reset();
        test_load();
        do_reset();
        test_branch();
        do_reset();
        test_jal();
        do_reset();
        test_timeout();
        do_reset();
        test_ack_at_limit();
        do_reset();
        test_illegal();
        do_reset();
        test_store_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, the maximum number of consecutive request cycles without acknowledge; 0 disables the timeout.
REQ-002 SHALL have parameter CNT_W, default 5, the width of the timeout counter; CNT_W SHALL satisfy 2^CNT_W > MEM_TIMEOUT.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have ports Op (input, 7 bits), Funct7 (input, 7 bits) and Funct3 (input, 3 bits): fields of the external instruction register.
REQ-006 SHALL have port Zero, input, 1 bit: ALU branch condition.
REQ-007 SHALL have ports imem_ack and dmem_ack, input, 1 bit each: memory acknowledges.
REQ-008 SHALL have ports imem_req and dmem_req, output, 1 bit each: memory requests.
REQ-009 SHALL have output strobes IRWrite, PCWrite, RegWrite and MemWrite, 1 bit each.
REQ-010 SHALL have outputs EXTOp (6 bits), ALUOp (5 bits), NPCOp (3 bits), ALUSrc (1 bit), WDSel (2 bits) and DMType (3 bits), encoded per ctrl_encode_def.v.
REQ-011 SHALL have outputs state (3 bits), bus_err (1 bit) and illegal (1 bit).

Function
REQ-012 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5.
REQ-013 FETCH: imem_req=1; on imem_ack, IRWrite=1 for that cycle and the next state is DECODE.
REQ-014 DECODE: one cycle; SHALL register all decoded fields (EXTOp, ALUOp, ALUSrc, WDSel, DMType and class) from Op/Funct7/Funct3; next state EXEC.
REQ-015 Registered decode fields SHALL drive the outputs from EXEC until the next DECODE.
REQ-016 EXEC, ALU/lui/auipc/jal/jalr classes: next state WB.
REQ-017 EXEC, load/store classes: next state MEM.
REQ-018 EXEC, branch class: PCWrite=1, NPCOp=001 if Zero else 000; next state FETCH.
REQ-019 MEM: dmem_req=1 and MemWrite=1 for stores; on dmem_ack, stores go to FETCH with PCWrite=1 and NPCOp=000, and loads go to WB.
REQ-020 WB: RegWrite=1 and PCWrite=1 for exactly one cycle; NPCOp=010 for jal, 100 for jalr, else 000; WDSel=10 for jal/jalr and 01 for loads; next state FETCH.
REQ-021 PCWrite SHALL assert exactly once per completed instruction; RegWrite at most once.
REQ-022 Timeout counter: SHALL increment each cycle a request is high without acknowledge and clear on acknowledge or state change.
REQ-023 If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT, the next state SHALL be TRAP and bus_err SHALL be set.
REQ-024 An acknowledge in the same cycle as timeout expiry SHALL win; no trap.
REQ-025 An acknowledge while the corresponding request is low SHALL be ignored.
REQ-026 TRAP SHALL be sticky until rst; all requests and strobes SHALL be 0 in TRAP.
REQ-027 Request outputs SHALL be Moore, decoded from state only.
REQ-028 Strobes SHALL be combinational from state, acknowledge inputs and the registered decode fields.

Reset
REQ-029 On rst=1: state=FETCH, counter=0, decode registers cleared to nop (ALUOp=00000, EXTOp=0, class none), bus_err=0, illegal=0.
REQ-030 Every output SHALL be 0 during reset except imem_req, which SHALL be 1 once rst deasserts.
REQ-031 Reset asserted mid-instruction SHALL abort it immediately with no strobe issued; requests drop asynchronously.

Configuration
REQ-032 Macro MC_CTRL_ILLEGAL_EN defined: an undecoded Op/Funct combination in DECODE SHALL go to TRAP and set illegal=1.
REQ-033 Macro MC_CTRL_ILLEGAL_EN undefined: an undecoded combination SHALL execute as nop: DECODE->EXEC, PCWrite=1, NPCOp=000, no RegWrite/MemWrite; illegal SHALL be tied 0.

Verification
REQ-034 addi x1,x0,5 (0x00500093), imem_ack immediate -> FETCH,DECODE,EXEC,WB over 4 cycles; ALUOp=00011, EXTOp=010000, ALUSrc=1, RegWrite and PCWrite high only in WB.
REQ-035 lw x2,0(x1) (0x0000A103), dmem_ack after 3 MEM cycles -> 7 cycles total, DMType=000, WDSel=01, one RegWrite.
REQ-036 beq x0,x0,8 (0x00000463) with Zero=1 -> 3 cycles, PCWrite in EXEC with NPCOp=001, no RegWrite; with Zero=0 -> NPCOp=000.
REQ-037 MEM_TIMEOUT=4, imem_ack held 0 -> TRAP after 4 request cycles, bus_err=1, imem_req=0, state=5; ack arriving in the 4th cycle -> no trap.
REQ-038 Instruction 0x0000007F -> TRAP with illegal=1 when MC_CTRL_ILLEGAL_EN is defined; 3-cycle nop with PCWrite, NPCOp=000 when undefined.
REQ-039 sw with rst pulsed during MEM -> MemWrite/dmem_req drop asynchronously, state=FETCH, no PCWrite.
